// File: rtl/num_one_stats_accumulator.sv
// Collects popcount results over a window of WINDOW samples and presents one
// report per window on a valid/ready port; reports are dropped while one is pending.
module num_one_stats_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned WINDOW     = 16,
  localparam int unsigned WCNT_W    = $clog2(WINDOW + 1),
  localparam int unsigned SUM_W     = CNT_W + WCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CNT_W-1:0]  in_num_one,
  input  logic [CNT_W-1:0]  in_max_idx,
  input  logic [CNT_W-1:0]  in_min_idx,
  input  logic              flush,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [SUM_W-1:0]  rpt_sum,
  output logic [WCNT_W-1:0] rpt_count,
  output logic [CNT_W-1:0]  rpt_max_idx,
  output logic [CNT_W-1:0]  rpt_min_idx,
  output logic [WCNT_W-1:0] rpt_zero_words,
  output logic              rpt_any_one,
  output logic              overflow,
  output logic              busy
);

  if (WINDOW < 1 || CNT_W < $clog2(DATA_WIDTH + 1)) begin : g_bad_param
    $error("num_one_stats_accumulator: WINDOW must be >= 1 and CNT_W must hold a popcount");
  end

  typedef enum logic {StIdle, StAccum} acc_state_e;
  typedef enum logic {StEmpty, StFull} out_state_e;

  acc_state_e        acc_state_q;
  out_state_e        out_state_q;
  logic [WCNT_W-1:0] cnt_q, cnt_d, zero_q, zero_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  max_q, max_d, min_q, min_d;
  logic              seen_q, seen_d;
  logic              capture, load;

  // Window totals including the current sample, so a capturing sample is counted.
  always_comb begin
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    max_d  = max_q;
    min_d  = min_q;
    zero_d = zero_q;
    seen_d = seen_q;
    if (in_valid) begin
      cnt_d = cnt_q + WCNT_W'(1);
      sum_d = sum_q + SUM_W'(in_num_one);
      if (in_num_one != '0) begin
        seen_d = 1'b1;
        if (!seen_q || in_max_idx > max_q) max_d = in_max_idx;
        if (!seen_q || in_min_idx < min_q) min_d = in_min_idx;
      end else begin
        zero_d = zero_q + WCNT_W'(1);
      end
    end
  end

  assign capture = (in_valid && cnt_d == WCNT_W'(WINDOW)) ||
                   (flush && (cnt_q != '0 || in_valid));
  assign load    = capture && (out_state_q == StEmpty || rpt_ready);

  always_ff @(posedge clk) begin
    if (rst || capture) begin
      acc_state_q <= StIdle;
      cnt_q       <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      zero_q      <= '0;
      seen_q      <= 1'b0;
    end else begin
      if (in_valid) acc_state_q <= StAccum;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      max_q  <= max_d;
      min_q  <= min_d;
      zero_q <= zero_d;
      seen_q <= seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q    <= StEmpty;
      rpt_sum        <= '0;
      rpt_count      <= '0;
      rpt_max_idx    <= '0;
      rpt_min_idx    <= '0;
      rpt_zero_words <= '0;
      rpt_any_one    <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (load) begin
        out_state_q    <= StFull;
        rpt_sum        <= sum_d;
        rpt_count      <= cnt_d;
        rpt_max_idx    <= max_d;
        rpt_min_idx    <= min_d;
        rpt_zero_words <= zero_d;
        rpt_any_one    <= seen_d;
      end else if (out_state_q == StFull && rpt_ready) begin
        out_state_q <= StEmpty;
      end
      // Pending report not taken: the new one is lost.
      if (capture && !load) overflow <= 1'b1;
    end
  end

  assign rpt_valid = (out_state_q == StFull);
  assign busy      = (acc_state_q == StAccum);

endmodule

// File: tb/tb_num_one_stats_accumulator.sv
// Directed bench: WINDOW=4 instance for most cases, WINDOW=1 instance for back-to-back reports.
module tb_num_one_stats_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid1, flush, rpt_ready, rpt_ready1;
  logic [3:0] in_num_one, in_max_idx, in_min_idx;

  logic       rpt_valid, rpt_any_one, overflow, busy;
  logic [6:0] rpt_sum;
  logic [2:0] rpt_count, rpt_zero_words;
  logic [3:0] rpt_max_idx, rpt_min_idx;

  logic       rpt_valid1, rpt_any_one1, overflow1, busy1;
  logic [4:0] rpt_sum1;
  logic [0:0] rpt_count1, rpt_zero_words1;
  logic [3:0] rpt_max_idx1, rpt_min_idx1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  num_one_stats_accumulator #(.DATA_WIDTH(8), .CNT_W(4), .WINDOW(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_num_one(in_num_one),
    .in_max_idx(in_max_idx), .in_min_idx(in_min_idx), .flush(flush),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_sum(rpt_sum), .rpt_count(rpt_count),
    .rpt_max_idx(rpt_max_idx), .rpt_min_idx(rpt_min_idx), .rpt_zero_words(rpt_zero_words),
    .rpt_any_one(rpt_any_one), .overflow(overflow), .busy(busy)
  );

  num_one_stats_accumulator #(.DATA_WIDTH(8), .CNT_W(4), .WINDOW(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_num_one(in_num_one),
    .in_max_idx(in_max_idx), .in_min_idx(in_min_idx), .flush(1'b0),
    .rpt_valid(rpt_valid1), .rpt_ready(rpt_ready1), .rpt_sum(rpt_sum1), .rpt_count(rpt_count1),
    .rpt_max_idx(rpt_max_idx1), .rpt_min_idx(rpt_min_idx1), .rpt_zero_words(rpt_zero_words1),
    .rpt_any_one(rpt_any_one1), .overflow(overflow1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] num, input logic [3:0] mx, input logic [3:0] mn);
    in_valid   = 1'b1;
    in_num_one = num;
    in_max_idx = mx;
    in_min_idx = mn;
    step();
    in_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; flush = 1'b0;
    rpt_ready = 1'b0; rpt_ready1 = 1'b0;
    in_num_one = '0; in_max_idx = '0; in_min_idx = '0;
    step(); step();
    rst = 1'b0;
    check("reset_valid", rpt_valid, 0);
    check("reset_sum", rpt_sum, 0);
    check("reset_overflow", overflow, 0);
    check("reset_busy", busy, 0);

    // Mixed window with one zero word
    rpt_ready = 1'b1;
    send(4, 5, 1);
    check("t1_busy", busy, 1);
    send(6, 6, 1);
    send(0, 9, 9);
    check("t1_not_yet", rpt_valid, 0);
    send(3, 7, 5);
    check("t1_valid", rpt_valid, 1);
    check("t1_sum", rpt_sum, 13);
    check("t1_count", rpt_count, 4);
    check("t1_max", rpt_max_idx, 7);
    check("t1_min", rpt_min_idx, 1);
    check("t1_zero", rpt_zero_words, 1);
    check("t1_any", rpt_any_one, 1);
    check("t1_busy_idle", busy, 0);
    step();
    check("t1_consumed", rpt_valid, 0);

    // All-zero window
    for (int i = 0; i < 4; i++) send(0, 3, 2);
    check("t2_valid", rpt_valid, 1);
    check("t2_sum", rpt_sum, 0);
    check("t2_zero", rpt_zero_words, 4);
    check("t2_any", rpt_any_one, 0);
    check("t2_max", rpt_max_idx, 0);
    check("t2_min", rpt_min_idx, 0);
    step();

    // Partial window via flush, then an empty flush
    send(8, 7, 0);
    send(1, 3, 3);
    flush = 1'b1; step(); flush = 1'b0;
    check("t3_valid", rpt_valid, 1);
    check("t3_count", rpt_count, 2);
    check("t3_sum", rpt_sum, 9);
    check("t3_max", rpt_max_idx, 7);
    check("t3_min", rpt_min_idx, 0);
    step();
    check("t3_consumed", rpt_valid, 0);
    flush = 1'b1; step(); flush = 1'b0;
    check("t3_empty_flush", rpt_valid, 0);
    step();
    check("t3_empty_flush2", rpt_valid, 0);

    // Stalled consumer: second report dropped
    rpt_ready = 1'b0;
    send(2, 3, 1); send(1, 2, 2); send(0, 0, 0); send(1, 0, 0);
    check("t4_valid", rpt_valid, 1);
    check("t4_sum", rpt_sum, 4);
    check("t4_no_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) send(4, 4, 0);
    check("t4_held_valid", rpt_valid, 1);
    check("t4_held_sum", rpt_sum, 4);
    check("t4_held_max", rpt_max_idx, 3);
    check("t4_held_zero", rpt_zero_words, 1);
    check("t4_overflow", overflow, 1);
    rpt_ready = 1'b1;
    step();
    check("t4_drained", rpt_valid, 0);
    check("t4_ovf_sticky", overflow, 1);

    // WINDOW=1: report every cycle
    rpt_ready1 = 1'b1;
    in_valid1 = 1'b1;
    in_num_one = 3; in_max_idx = 5; in_min_idx = 2;
    step();
    check("t5_valid_a", rpt_valid1, 1);
    check("t5_sum_a", rpt_sum1, 3);
    check("t5_max_a", rpt_max_idx1, 5);
    in_num_one = 0; in_max_idx = 9; in_min_idx = 9;
    step();
    check("t5_valid_b", rpt_valid1, 1);
    check("t5_sum_b", rpt_sum1, 0);
    check("t5_zero_b", rpt_zero_words1, 1);
    check("t5_any_b", rpt_any_one1, 0);
    in_num_one = 7; in_max_idx = 7; in_min_idx = 1;
    step();
    check("t5_valid_c", rpt_valid1, 1);
    check("t5_sum_c", rpt_sum1, 7);
    check("t5_min_c", rpt_min_idx1, 1);
    check("t5_count_c", rpt_count1, 1);
    check("t5_ovf", overflow1, 0);
    in_valid1 = 1'b0;
    step();
    check("t5_idle", rpt_valid1, 0);

    // Reset mid-window discards the partial window
    send(5, 5, 1);
    send(2, 6, 4);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_valid", rpt_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ovf", overflow, 0);
    check("t6_sum", rpt_sum, 0);
    for (int i = 0; i < 3; i++) send(1, 1, 1);
    check("t6_partial", rpt_valid, 0);
    send(1, 1, 1);
    check("t6_valid2", rpt_valid, 1);
    check("t6_count", rpt_count, 4);
    check("t6_sum2", rpt_sum, 4);
    check("t6_max", rpt_max_idx, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
